// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cipher_pkg
// Description : Shared types and configuration-word layout helpers for the
//               dual_xor_stream_cipher configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_pkg;

    // Sequencer states with a fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        ACTIVE = 2'd3
    } seq_state_t;

    // Length of the cipher's serial configuration chain for an M-bit LFSR pair
    function automatic int cfg_w(input int m);
        return 4 * m + 2;
    endfunction

    // Single-bit control fields sit at the top of the configuration word
    function automatic int a_mux_bit(input int m);
        return cfg_w(m) - 1;
    endfunction

    function automatic int d_en_bit(input int m);
        return cfg_w(m) - 2;
    endfunction

    // LSB offsets of the four M-bit slices: tx taps, tx state, rx taps, rx state
    function automatic int tx_tap_lo(input int m);
        return 0;
    endfunction

    function automatic int tx_state_lo(input int m);
        return m;
    endfunction

    function automatic int rx_tap_lo(input int m);
        return 2 * m;
    endfunction

    function automatic int rx_state_lo(input int m);
        return 3 * m;
    endfunction

endpackage : cipher_pkg
`default_nettype wire

// File: rtl/piso_sipo_shifter.sv
`default_nettype none
// ============================================================================
// Module      : piso_sipo_shifter
// Description : Paired load/shift registers. The outgoing register serialises
//               a parallel word LSB-first; the incoming register collects the
//               serial return stream at its MSB so the first bit ends at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_sipo_shifter #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_word,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] rb_next
);

    logic [W-1:0] r_sr;
    logic [W-1:0] r_rb_sr;

    // Load discards any stale readback; shift moves both registers one place right
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= '0;
            r_rb_sr <= '0;
        end else if (load) begin
            r_sr    <= load_word;
            r_rb_sr <= '0;
        end else if (shift) begin
            r_sr    <= {1'b0, r_sr[W-1:1]};
            r_rb_sr <= rb_next;
        end
    end

    assign ser_out = r_sr[0];
    // Readback value after the current bit is absorbed, so the last bit can be
    // captured on the same edge it arrives
    assign rb_next = {ser_in, r_rb_sr[W-1:1]};

endmodule : piso_sipo_shifter
`default_nettype wire

// File: rtl/cipher_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cipher_cfg_sequencer
// Description : Streams a parallel configuration word into the cipher's serial
//               configuration port, captures the displaced configuration as a
//               readback word and gates the keystream enables from run bits.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_cfg_sequencer
    import cipher_pkg::*;
#(
    parameter int M          = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*M+1:0]        cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  run_tx,
    input  logic                  run_rx,
    output logic                  cfg_en,
    output logic                  cfg_i,
    input  logic                  cfg_o,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic [4*M+1:0]        rb_word,
    output logic                  rb_valid,
    output logic                  configured,
    output logic                  busy
);

    localparam int CFG_W = cfg_w(M);
    localparam int CNT_W = $clog2(CFG_W);
    localparam int SET_W = 4;
    localparam logic [CNT_W-1:0] C_LAST_BIT   = CNT_W'(CFG_W - 1);
    localparam logic [SET_W-1:0] C_LAST_SETTLE = SET_W'(SETTLE_CYC - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [SET_W-1:0] r_set_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_last_bit;
    logic             w_sr0;
    logic [CFG_W-1:0] w_rb_next;
    logic             r_tx_en;
    logic             r_rx_en;
    logic [CFG_W-1:0] r_rb_word;
    logic             r_rb_valid;
    logic             r_configured;

    assign w_last_bit = (r_bit_cnt == C_LAST_BIT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus load/shift strobes for the shifter pair
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE, ACTIVE: begin
                if (cfg_valid) begin
                    w_state_next = SHIFT;
                    w_load       = 1'b1;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last_bit) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_set_cnt == C_LAST_SETTLE) begin
                    w_state_next = ACTIVE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit and settle counters clear whenever their state is not active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            r_bit_cnt <= (r_state == SHIFT)  ? r_bit_cnt + 1'b1 : '0;
            r_set_cnt <= (r_state == SETTLE) ? r_set_cnt + 1'b1 : '0;
        end
    end

    // Enables follow the run bits one cycle late and drop on the edge that
    // starts a new shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en <= 1'b0;
            r_rx_en <= 1'b0;
        end else begin
            r_tx_en <= (w_state_next == ACTIVE) & run_tx;
            r_rx_en <= (w_state_next == ACTIVE) & run_rx;
        end
    end

    // Readback capture on the edge that absorbs the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_word    <= '0;
            r_rb_valid   <= 1'b0;
            r_configured <= 1'b0;
        end else begin
            r_rb_valid <= (r_state == SHIFT) & w_last_bit;
            if ((r_state == SHIFT) && w_last_bit) begin
                r_rb_word    <= w_rb_next;
                r_configured <= 1'b1;
            end
        end
    end

    piso_sipo_shifter #(
        .W (CFG_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_shift),
        .load_word (cfg_word),
        .ser_in    (cfg_o),
        .ser_out   (w_sr0),
        .rb_next   (w_rb_next)
    );

    assign cfg_en     = (r_state == SHIFT);
    assign cfg_i      = (r_state == SHIFT) & w_sr0;
    assign cfg_ready  = (r_state == IDLE) | (r_state == ACTIVE);
    assign busy       = (r_state == SHIFT) | (r_state == SETTLE);
    assign tx_en      = r_tx_en;
    assign rx_en      = r_rx_en;
    assign rb_word    = r_rb_word;
    assign rb_valid   = r_rb_valid;
    assign configured = r_configured;

endmodule : cipher_cfg_sequencer
`default_nettype wire

// File: doc/cipher_cfg_sequencer.md
# cipher_cfg_sequencer

Controller that owns the serial configuration port of `dual_xor_stream_cipher`. It accepts a parallel configuration word over a valid/ready handshake and streams it LSB-first into `cfg_i` while holding `cfg_en`. It captures the displaced configuration from `cfg_o` as a readback word, then gates the cipher's `tx_en`/`rx_en` from requester run bits. It sits between the register/host interface and the cipher core.

## Interface
- `M`, 32: LFSR width of the attached cipher. `CFG_W` = 4*M+2 is a derived localparam.
- `SETTLE_CYC`, 2: idle cycles after a shift before streaming is re-enabled. Legal range 1..15.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; tie to the cipher's `rst`
- `cfg_word`  in  CFG_W  new configuration; bit 0 lands in cipher `cfg_reg[0]`
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  sequencer can accept `cfg_word`
- `run_tx`  in  1  requester wants the TX keystream running
- `run_rx`  in  1  requester wants the RX keystream running
- `cfg_en`  out  1  to cipher `cfg_en`
- `cfg_i`  out  1  to cipher `cfg_i`
- `cfg_o`  in  1  from cipher `cfg_o`
- `tx_en`  out  1  to cipher `tx_en`
- `rx_en`  out  1  to cipher `rx_en`
- `rb_word`  out  CFG_W  configuration displaced by the last load
- `rb_valid`  out  1  one-cycle pulse when `rb_word` is updated
- `configured`  out  1  at least one load has completed since reset
- `busy`  out  1  state is SHIFT or SETTLE

## Operation
The sequencer has four states.
- **IDLE**: reset state. `cfg_ready`=1. `tx_en`=`rx_en`=0.
  - `cfg_valid` → SHIFT.
- **SHIFT**: `cfg_en`=1. `cfg_i`=`sr[0]`. `cfg_ready`=0. `tx_en`=`rx_en`=0.
  - Each cycle, `sr` shifts right and `cfg_o` is shifted into `rb_sr` at the MSB.
  - The bit counter runs 0..CFG_W-1.
  - When the count reaches CFG_W-1 (the last bit) → SETTLE.
- **SETTLE**: `cfg_en`=0. `tx_en`=`rx_en`=0. `cfg_ready`=0.
  - The settle counter counts SETTLE_CYC cycles → ACTIVE.
  - On the first SETTLE cycle: `rb_word` ← `rb_sr`, `rb_valid`=1, `configured` ← 1.
- **ACTIVE**: `cfg_ready`=1. `tx_en`=`run_tx`. `rx_en`=`run_rx`. Both are registered, so they follow the run bits with 1 cycle of lag.
  - `cfg_valid` → SHIFT. `tx_en`/`rx_en` drop in the same cycle that `cfg_en` rises. The cipher's internal gating makes this overlap safe.

Handshake and boundary rules:
- A transfer happens on `cfg_valid & cfg_ready` at a rising edge. `cfg_word` is latched into `sr` on that edge, and the `rb_sr` contents are discarded.
- `cfg_valid` is ignored while busy. Requesters must hold it until `cfg_ready` is seen.
- The run bits have no effect outside ACTIVE. No buffering is done.
- Reset mid-SHIFT returns to IDLE with `configured`=0. The cipher resets to its defaults on the same `rst`, so no partial load survives.
- The bit counter width is $clog2(CFG_W). There is no wrap; the state exits at CFG_W-1.

## Timing
- Reset values:
  - `cfg_en`, `cfg_i`, `tx_en`, `rx_en`, `rb_valid`, `busy`, `configured` = 0
  - `cfg_ready` = 1
  - `rb_word` = 0
- All outputs are registered or decoded directly from the state register. None depends combinationally on an input.
- Accept edge T:
  - `cfg_en`=1 over cycles T+1 .. T+CFG_W, exactly CFG_W cycles, matching the cipher's load counter.
  - `rb_valid` at T+CFG_W+1.
  - `cfg_ready` and the run-gated enables resume at T+CFG_W+SETTLE_CYC+1.
- `cfg_o` is sampled in the same cycle `cfg_i` is driven. The cipher's `cfg_reg[0]` is valid then, because the cipher forces `cfg_o`=0 only when `cfg_en`=0.
- `rb_word` bit 0 is the first bit sampled.

## Structure
- Shared package `cipher_pkg`:
  - state enum `{IDLE, SHIFT, SETTLE, ACTIVE}`
  - function `cfg_w(M)` = 4*M+2
  - field-offset constants for `a_mux` (CFG_W-1), `d_en` (CFG_W-2), and the tx/rx tap/state slices, so benches build `cfg_word` symbolically.
- One sub-module is natural: `piso_sipo_shifter`, a CFG_W-bit load/shift register pair with serial in/out.
- The FSM and counters live in the top.

## Test plan
For all scenarios, M=4 (CFG_W=18) and SETTLE_CYC=2.
- **Reset then load**: reset, then load `cfg_word`=18'h2_A5C3.
  - Expect `cfg_en` high for exactly 18 cycles.
  - `cfg_i` serial sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0,1 (LSB first).
  - `rb_valid` at T+19.
  - `rb_word` equals the cipher's reset default (with `a_mux`=0 and `d_en`=0).
- **Second load**: load 18'h0_1234. Expect `rb_word`=18'h2_A5C3, since the LFSRs never ran.
- **Run gating**: in ACTIVE, `run_tx`=1 and `run_rx`=0.
  - `tx_en`=1 one cycle later and `rx_en` stays 0.
  - Check cipher `tx_e` = `tx_p` ^ keystream against a model.
- **Reconfigure while running**: `cfg_valid` during ACTIVE with both run bits set.
  - `tx_en`/`rx_en` fall on the cycle `cfg_en` rises.
  - `rb_word` reflects the advanced LFSR states.
- **Busy ignore**: pulse `cfg_valid` with a different word mid-SHIFT.
  - The shift sequence is unchanged and no extra load follows.
- **Reset mid-shift**: assert `rst` at bit 7. Expect IDLE, `configured`=0, `cfg_en`=0 the next cycle, and `rb_valid` never pulses.
